pe_wgt_loader: RTL
==================

Name: pe_wgt_loader

Overview:
- Drives the weight-load chain and the pop line at the head of a systolic PE row/column.
- Accepts a stream of weights through a valid/ready handshake and emits one load beat per weight, tagged with ascending PE IDs 0..NUM_PE-1.
- Tracks how many of the two per-PE weight banks hold unconsumed weights, and gates load commands and pop (bank switch) requests on that count.
- Output feeds the first PE's i_load_vld/i_load_id/i_load_data and i_pop_vld.

Parameters:
- NUM_PE, 16, number of PEs on the load chain (1..2**ID_WIDTH).
- ID_WIDTH, 6, width of the PE ID field.
- IN_DATA_WIDTH, 8, weight width.
- FLUSH_CYC, NUM_PE, cycles after the last beat before the bank counts as resident (chain propagation, 1 cycle per PE).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_start  in  1  request to load one bank (NUM_PE weights)
- o_busy  out  1  high while not IDLE
- o_done  out  1  one-cycle pulse when the bank is resident
- o_start_err  out  1  one-cycle pulse when i_start is rejected
- i_wgt_vld  in  1  weight stream valid
- o_wgt_rdy  out  1  weight stream ready
- i_wgt_data  in  IN_DATA_WIDTH  weight
- o_load_vld  out  1  load beat valid
- o_load_id  out  ID_WIDTH  target PE ID
- o_load_data  out  IN_DATA_WIDTH  weight
- i_pop_req  in  1  request to retire the current bank
- o_pop_vld  out  1  one-cycle pop pulse to the chain
- o_pop_err  out  1  one-cycle pulse when a pop is rejected
- o_fill  out  2  resident bank count, 0..2

Behaviour:
- Reset: all outputs 0; state IDLE; fill=0; ID counter=0. Reset mid-load abandons the bank with no o_done. The PE chain shares the same rst, so its bank indices realign.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE->LOAD: on i_start when fill<2.
  - i_start with fill==2, or while not IDLE: ignored, o_start_err=1 for one cycle.
- LOAD:
  - o_wgt_rdy=1.
  - Each accepted beat (i_wgt_vld&&o_wgt_rdy) registers o_load_vld=1, o_load_id=id_cnt, o_load_data=i_wgt_data on the next cycle (latency 1).
  - id_cnt increments per accepted beat.
  - Gaps are allowed; o_load_vld=0 in cycles with no accepted beat.
  - After beat with id_cnt==NUM_PE-1: id_cnt->0, go to FLUSH. o_wgt_rdy=0 from the following cycle.
- FLUSH: count FLUSH_CYC cycles, then go to DONE.
- DONE: one cycle. o_done=1, fill+=1, then IDLE.
- o_wgt_rdy=0 in all states except LOAD.
- Pop:
  - Pop is independent of the FSM.
  - i_pop_req with fill>=1: o_pop_vld=1 on the next cycle, fill-=1.
  - i_pop_req with fill==0: o_pop_err=1 next cycle, no pulse.
  - A pop is allowed during LOAD/FLUSH.
- Simultaneous DONE increment and accepted pop: fill unchanged (net 0).
- i_start is checked against the registered fill, before any same-cycle pop decrement.
- fill never exceeds 2 or drops below 0 (guaranteed by the acceptance rules; assert in the bench).
- o_load_id width: id_cnt zero-extended to ID_WIDTH.

Decomposition:
- Shared package utils_pkg holds:
  - a typedef enum for the loader states (IDLE/LOAD/FLUSH/DONE);
  - a localparam NUM_WGT_BANKS=2.
- No sub-module: counters and FSM stay in one module.

Test Plan:
1. Reset, i_start, stream 16 weights 0x01..0x10 back-to-back -> o_load_id 0..15 with matching data, each 1 cycle after acceptance. o_done 16 cycles after the last beat; o_fill=1.
2. Same load with i_wgt_vld toggling every other cycle -> identical beat sequence with gaps; no beat while i_wgt_vld=0; o_wgt_rdy drops after beat 15.
3. Two loads, then third i_start -> o_start_err pulse, state stays IDLE, o_fill=2. Then i_pop_req -> o_pop_vld pulse, o_fill=1; third i_start now accepted.
4. i_pop_req with o_fill=0 -> o_pop_err pulse, o_pop_vld stays 0, o_fill stays 0.
5. fill=1, i_pop_req asserted in the DONE cycle of the second load -> o_pop_vld pulse and o_done pulse; o_fill stays 1.
6. rst asserted after beat 7 of a load -> next cycle all outputs 0, o_fill=0. A fresh load starts at o_load_id 0; no o_done for the aborted bank.

Source files
------------

// File: rtl/utils_pkg.sv
// Shared types and constants for the PE weight loader.
package utils_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } ldr_state_e;

  localparam int NUM_WGT_BANKS = 2;

endpackage

// File: rtl/pe_wgt_loader.sv
// Head-of-chain weight loader: streams one bank of weights to the PE chain,
// tracks resident banks and gates load starts and pops on that count.
module pe_wgt_loader
  import utils_pkg::*;
#(
  parameter int NUM_PE        = 16,
  parameter int ID_WIDTH      = 6,
  parameter int IN_DATA_WIDTH = 8,
  parameter int FLUSH_CYC     = NUM_PE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_start_err,
  input  logic                     i_wgt_vld,
  output logic                     o_wgt_rdy,
  input  logic [IN_DATA_WIDTH-1:0] i_wgt_data,
  output logic                     o_load_vld,
  output logic [ID_WIDTH-1:0]      o_load_id,
  output logic [IN_DATA_WIDTH-1:0] o_load_data,
  input  logic                     i_pop_req,
  output logic                     o_pop_vld,
  output logic                     o_pop_err,
  output logic [1:0]               o_fill
);

  localparam int FLUSH_W = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC);

  ldr_state_e          state, state_nxt;
  logic [ID_WIDTH-1:0] id_cnt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic [1:0]          fill;
  logic                beat;
  logic                last_beat;
  logic                start_rej;
  logic                done_inc;
  logic                pop_ok;

  assign last_beat = (id_cnt == ID_WIDTH'(NUM_PE - 1));
  // Pop acceptance looks only at the registered fill, independent of the FSM.
  assign pop_ok    = i_pop_req && (fill != 2'd0);
  assign o_fill    = fill;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    beat      = 1'b0;
    start_rej = 1'b0;
    done_inc  = 1'b0;
    o_busy    = (state != ST_IDLE);
    o_wgt_rdy = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          if (fill < 2'(NUM_WGT_BANKS)) state_nxt = ST_LOAD;
          else                          start_rej = 1'b1;
        end
      end
      ST_LOAD: begin
        o_wgt_rdy = 1'b1;
        beat      = i_wgt_vld;
        start_rej = i_start;
        if (beat && last_beat) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        start_rej = i_start;
        if (flush_cnt == FLUSH_W'(FLUSH_CYC - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        start_rej = i_start;
        o_done    = 1'b1;
        done_inc  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_cnt      <= '0;
      flush_cnt   <= '0;
      fill        <= 2'd0;
      o_load_vld  <= 1'b0;
      o_load_id   <= '0;
      o_load_data <= '0;
      o_pop_vld   <= 1'b0;
      o_pop_err   <= 1'b0;
      o_start_err <= 1'b0;
    end else begin
      o_load_vld  <= beat;
      o_pop_vld   <= pop_ok;
      o_pop_err   <= i_pop_req && !pop_ok;
      o_start_err <= start_rej;

      if (beat) begin
        o_load_id   <= id_cnt;
        o_load_data <= i_wgt_data;
        id_cnt      <= last_beat ? '0 : id_cnt + 1'b1;
      end

      if (state == ST_FLUSH) flush_cnt <= flush_cnt + 1'b1;
      else                   flush_cnt <= '0;

      // A bank becoming resident and one retiring in the same cycle cancel out.
      case ({done_inc, pop_ok})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
    end
  end

endmodule
